demux_reg_bank_16: RTL and testbench
====================================

// Module: demux_reg_bank_16
// PURPOSE
//   Write side of the 16-entry register bank: a registered 1-to-16 demultiplexer.
//   It steers one WIDTH-bit write value into one of 16 holding registers,
//   selected by a 4-bit index.
//   All 16 register values are driven out in parallel.
//   The datapath's 16:1 read multiplexers pick from these outputs.
//   A one-cycle one-hot write strobe tells downstream logic which entry changed.
// PARAMETERS
//   WIDTH        4      data width of each entry, write_data and every output_N
//   RESET_VALUE  0      value loaded into every entry on reset or clear (WIDTH bits)
// PORTS
//   clk            input   1        rising-edge clock
//   reset          input   1        asynchronous, active-high reset
//   clear          input   1        synchronous clear of all 16 entries
//   write_enable   input   1        write request for the current cycle
//   write_select   input   4        index of the entry to write (0..15)
//   write_data     input   WIDTH    value to store
//   output_0..15   output  WIDTH    registered contents of entries 0..15
//   write_strobe   output  16       one-hot marker of the entry written on the last edge
//   clear_done     output  1        high for one cycle after a clear took effect
// BEHAVIOUR
//   Reset (asynchronous, takes effect immediately, independent of clk)
//   - reset=1: all output_N = RESET_VALUE, write_strobe = 16'h0000, clear_done = 0.
//   - Outputs hold these values for as long as reset stays high.
//   - The first edge after reset falls is processed normally.
//   - A write pending when reset asserts is lost.
//   Priority on each rising edge of clk (reset low)
//   1. clear=1
//      - All entries <= RESET_VALUE. write_enable is ignored.
//      - write_strobe <= 0, clear_done <= 1.
//   2. Otherwise, write_enable=1
//      - Entry[write_select] <= write_data. All other entries hold.
//      - write_strobe <= (16'h0001 << write_select), clear_done <= 0.
//   3. Otherwise (idle)
//      - All entries hold. write_strobe <= 0, clear_done <= 0.
//   Timing and decode rules
//   - Latency is one cycle: new data appears on output_N right after the capturing edge.
//   - There is no combinational path from any input to any output.
//   - write_strobe and clear_done are pulses. Each is high for exactly one cycle per event.
//   - Back-to-back writes to the same index update the entry every cycle, last value wins.
//   - Back-to-back writes to the same index keep the strobe high on consecutive cycles.
//   - Writes to different indices on consecutive cycles move the strobe bit each cycle.
//     Earlier entries keep their values.
//   - write_select is a full 4-bit decode: every code maps to one entry.
//     Exactly one strobe bit is set per write.
//   - write_data is stored as-is, with no sign or zero extension.
//   - X or Z on write_select while write_enable=0 must not disturb any entry.
// TESTING
//   1. Assert reset mid-cycle after entries are loaded
//      -> every output_N = RESET_VALUE and write_strobe = 0 immediately, without waiting for a clk edge.
//   2. WIDTH=4: write 4'hA to index 0, 4'h5 to index 15, 4'h3 to index 7 on three consecutive cycles
//      -> output_0=A, output_15=5, output_7=3, others 0.
//      -> write_strobe sequence 0001, 8000, 0080 (hex).
//   3. Sweep all 16 indices, writing value = index
//      -> output_N = N for N=0..15, strobe walks 1<<N.
//      -> Then idle: strobe = 0 and all entries hold.
//   4. clear=1 and write_enable=1 (index 3, data F) on the same edge
//      -> all entries 0, output_3 stays 0, clear_done=1 for one cycle, write_strobe=0.
//   5. Write 1,2,3 to index 9 on consecutive cycles
//      -> output_9 reads 1,2,3 one cycle after each edge.
//      -> write_strobe[9] stays high for 3 cycles, then drops.
//   6. write_enable=0 with write_select toggling randomly for 20 cycles
//      -> no entry changes, write_strobe = 0 throughout.

Source files
------------

// File: rtl/demux_reg_bank_16.sv
// Registered 1-to-16 write demultiplexer: steers write_data into one of 16 entries,
// exposes all entries in parallel, and flags each write/clear with one-cycle pulses.
module demux_reg_bank_16 #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             write_enable,
  input  logic [3:0]       write_select,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] output_0,
  output logic [WIDTH-1:0] output_1,
  output logic [WIDTH-1:0] output_2,
  output logic [WIDTH-1:0] output_3,
  output logic [WIDTH-1:0] output_4,
  output logic [WIDTH-1:0] output_5,
  output logic [WIDTH-1:0] output_6,
  output logic [WIDTH-1:0] output_7,
  output logic [WIDTH-1:0] output_8,
  output logic [WIDTH-1:0] output_9,
  output logic [WIDTH-1:0] output_10,
  output logic [WIDTH-1:0] output_11,
  output logic [WIDTH-1:0] output_12,
  output logic [WIDTH-1:0] output_13,
  output logic [WIDTH-1:0] output_14,
  output logic [WIDTH-1:0] output_15,
  output logic [15:0]      write_strobe,
  output logic             clear_done
);

  logic [WIDTH-1:0] entry_vals [16];
  logic [15:0]      write_strobe_q, write_strobe_d;
  logic             clear_done_q, clear_done_d;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_q, entry_d;

      // write_enable gates the select compare so an unknown index while idle
      // can never reach an entry.
      always_comb begin
        entry_d = entry_q;
        if (clear) begin
          entry_d = RESET_VALUE;
        end else if (write_enable && (write_select == 4'(gi))) begin
          entry_d = write_data;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_q <= RESET_VALUE;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign entry_vals[gi] = entry_q;
    end
  endgenerate

  always_comb begin
    write_strobe_d = 16'h0000;
    clear_done_d   = 1'b0;
    if (clear) begin
      clear_done_d = 1'b1;
    end else if (write_enable) begin
      write_strobe_d = 16'h0001 << write_select;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_strobe_q <= 16'h0000;
      clear_done_q   <= 1'b0;
    end else begin
      write_strobe_q <= write_strobe_d;
      clear_done_q   <= clear_done_d;
    end
  end

  assign write_strobe = write_strobe_q;
  assign clear_done   = clear_done_q;

  assign output_0  = entry_vals[0];
  assign output_1  = entry_vals[1];
  assign output_2  = entry_vals[2];
  assign output_3  = entry_vals[3];
  assign output_4  = entry_vals[4];
  assign output_5  = entry_vals[5];
  assign output_6  = entry_vals[6];
  assign output_7  = entry_vals[7];
  assign output_8  = entry_vals[8];
  assign output_9  = entry_vals[9];
  assign output_10 = entry_vals[10];
  assign output_11 = entry_vals[11];
  assign output_12 = entry_vals[12];
  assign output_13 = entry_vals[13];
  assign output_14 = entry_vals[14];
  assign output_15 = entry_vals[15];

endmodule

// File: tb/tb_demux_reg_bank_16.sv
// Randomized bench for demux_reg_bank_16: a per-cycle compare against a behavioural
// register-file model, plus literal checks of the directed scenarios.
module tb_demux_reg_bank_16;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic             write_enable = 1'b0;
  logic [3:0]       write_select = 4'h0;
  logic [WIDTH-1:0] write_data = '0;
  logic [WIDTH-1:0] dut_out [16];
  logic [15:0]      write_strobe;
  logic             clear_done;

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  always #5 clk = ~clk;

  demux_reg_bank_16 #(.WIDTH(WIDTH), .RESET_VALUE(4'h0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .write_enable(write_enable),
    .write_select(write_select), .write_data(write_data),
    .output_0(dut_out[0]),   .output_1(dut_out[1]),   .output_2(dut_out[2]),
    .output_3(dut_out[3]),   .output_4(dut_out[4]),   .output_5(dut_out[5]),
    .output_6(dut_out[6]),   .output_7(dut_out[7]),   .output_8(dut_out[8]),
    .output_9(dut_out[9]),   .output_10(dut_out[10]), .output_11(dut_out[11]),
    .output_12(dut_out[12]), .output_13(dut_out[13]), .output_14(dut_out[14]),
    .output_15(dut_out[15]),
    .write_strobe(write_strobe), .clear_done(clear_done)
  );

  // Behavioural model: a plain array of 16 values plus the last event.
  logic [WIDTH-1:0] m_mem [16];
  logic [15:0]      m_strobe;
  logic             m_clear_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_mem[i] <= '0;
      m_strobe     <= 16'h0000;
      m_clear_done <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < 16; i++) m_mem[i] <= '0;
      m_strobe     <= 16'h0000;
      m_clear_done <= 1'b1;
    end else if (write_enable) begin
      m_mem[int'(write_select)] <= write_data;
      m_strobe     <= 16'(1) << int'(write_select);
      m_clear_done <= 1'b0;
    end else begin
      m_strobe     <= 16'h0000;
      m_clear_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 16; i++) chk($sformatf("model_out%0d", i), 16'(dut_out[i]), 16'(m_mem[i]));
      chk("model_strobe", write_strobe, m_strobe);
      chk("model_clear_done", 16'(clear_done), 16'(m_clear_done));
    end
  end

  // Drive one edge's worth of inputs; returns 1 ns after the capturing edge.
  task automatic cyc(input logic c, input logic we, input logic [3:0] sel, input logic [WIDTH-1:0] d);
    clear = c; write_enable = we; write_select = sel; write_data = d;
    @(posedge clk);
    #1;
    $display("cycle t=%0t clear=%0b we=%0b sel=%0d data=%h strobe=%h clear_done=%0b",
             $time, c, we, sel, d, write_strobe, clear_done);
  endtask

  initial begin
    logic [15:0] exp_str;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) chk($sformatf("reset_out%0d", i), 16'(dut_out[i]), 16'h0);
    chk("reset_strobe", write_strobe, 16'h0000);
    chk("reset_clear_done", 16'(clear_done), 16'h0);
    reset = 1'b0;
    check_en = 1'b1;

    // Three writes on consecutive edges
    cyc(0, 1, 4'd0, 4'hA);  chk("t2_strobe0", write_strobe, 16'h0001);
    cyc(0, 1, 4'd15, 4'h5); chk("t2_strobe1", write_strobe, 16'h8000);
    cyc(0, 1, 4'd7, 4'h3);  chk("t2_strobe2", write_strobe, 16'h0080);
    chk("t2_out0", 16'(dut_out[0]), 16'hA);
    chk("t2_out15", 16'(dut_out[15]), 16'h5);
    chk("t2_out7", 16'(dut_out[7]), 16'h3);
    chk("t2_out1", 16'(dut_out[1]), 16'h0);

    // Full index sweep, then idle
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 4'(i), 4'(i));
      exp_str = 16'h0001 << i;
      chk($sformatf("t3_strobe%0d", i), write_strobe, exp_str);
    end
    cyc(0, 0, 4'd0, 4'h0);
    chk("t3_idle_strobe", write_strobe, 16'h0000);
    for (int i = 0; i < 16; i++) chk($sformatf("t3_out%0d", i), 16'(dut_out[i]), 16'(i));

    // Clear wins over a simultaneous write
    cyc(1, 1, 4'd3, 4'hF);
    chk("t4_out3", 16'(dut_out[3]), 16'h0);
    chk("t4_out12", 16'(dut_out[12]), 16'h0);
    chk("t4_clear_done", 16'(clear_done), 16'h1);
    chk("t4_strobe", write_strobe, 16'h0000);
    cyc(0, 0, 4'd3, 4'h0);
    chk("t4_clear_done_pulse", 16'(clear_done), 16'h0);

    // Back-to-back writes to one index
    for (int v = 1; v <= 3; v++) begin
      cyc(0, 1, 4'd9, 4'(v));
      chk($sformatf("t5_out9_%0d", v), 16'(dut_out[9]), 16'(v));
      chk($sformatf("t5_strobe9_%0d", v), 16'(write_strobe[9]), 16'h1);
    end
    cyc(0, 0, 4'd9, 4'h0);
    chk("t5_strobe_drop", write_strobe, 16'h0000);

    // Idle with a wandering select
    for (int i = 0; i < 16; i++) cyc(0, 1, 4'(i), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      chk("t6_strobe", write_strobe, 16'h0000);
    end

    // Asynchronous reset in the middle of a cycle
    cyc(0, 1, 4'd4, 4'h6);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) chk($sformatf("t1_out%0d", i), 16'(dut_out[i]), 16'h0);
    chk("t1_strobe", write_strobe, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6),
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) == 0) begin
        #3;
        reset = 1'b1;
        #2;
        chk("rand_async_strobe", write_strobe, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
